// File: rtl/microwave_timer_ctrl_pkg.sv
// Shared state encoding, BCD digit limits and load-value validation
// for the microwave timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COOK  = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  // Packed as {min_tens, min_ones, sec_tens, sec_ones}.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    return (t[15:12] <= BCD_MAX_UNITS)    &&
           (t[11:8]  <= BCD_MAX_UNITS)    &&
           (t[7:4]   <= BCD_MAX_SEC_TENS) &&
           (t[3:0]   <= BCD_MAX_UNITS);
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Request inputs and status outputs of the microwave timer controller.
// The controller takes the slave modport; its driver takes master.
interface microwave_timer_ctrl_if;
  logic        tick;
  logic [15:0] data;
  logic        loadn;
  logic        startn;
  logic        stopn;
  logic        door_closed;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        mag_on;
  logic        done;
  logic        load_err;
  logic [2:0]  state;

  modport master (
    output tick, data, loadn, startn, stopn, door_closed,
    input  min_tens, min_ones, sec_tens, sec_ones, mag_on, done, load_err, state
  );

  modport slave (
    input  tick, data, loadn, startn, stopn, door_closed,
    output min_tens, min_ones, sec_tens, sec_ones, mag_on, done, load_err, state
  );
endinterface

// File: rtl/microwave_timer_ctrl_digit.sv
// One BCD down-counting digit: wraps 0 -> MAX_VAL with a borrow out,
// synchronous clear and parallel load.
module bcd_down_digit #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] value_o,
  output logic       borrow_o,
  output logic       zero_o
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (en_i) begin
      value_d = (value_q == '0) ? MAX_VAL : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o  = value_q;
  assign zero_o   = (value_q == '0);
  assign borrow_o = en_i && zero_o;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: IDLE/COOK/PAUSE/DONE control FSM driving a
// four-digit mm:ss BCD down-counter and the done-hold tick counter.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic                   clock,
  input  logic                   clearn,
  microwave_timer_ctrl_if.slave  bus
);

  localparam logic [3:0] DONE_LAST = 4'(DONE_TICKS - 1);

  state_e     state_q, state_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       mag_on_q, done_q, load_err_q, load_err_d;
  logic       dig_clr, dig_load, dig_dec;

  logic       so_zero, st_zero, mo_zero, mt_zero;
  logic       so_borrow, st_borrow, mo_borrow, mt_borrow_unused;
  logic       time_zero, time_one, start_req, load_ok;

  assign time_zero = so_zero && st_zero && mo_zero && mt_zero;
  assign time_one  = st_zero && mo_zero && mt_zero && (bus.sec_ones == 4'd1);
  assign start_req = !bus.startn && bus.door_closed;
  assign load_ok   = bcd_time_valid(bus.data);

  // Door-open only has an action in COOK; elsewhere it merely masks startn.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = '0;
    dig_clr    = 1'b0;
    dig_load   = 1'b0;
    dig_dec    = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        if (!bus.stopn) begin
          state_d = IDLE;
          dig_clr = 1'b1;
        end else if (start_req) begin
          if (!time_zero) state_d = COOK;
        end else if (!bus.loadn) begin
          if (load_ok) dig_load   = 1'b1;
          else         load_err_d = 1'b1;
        end
      end
      COOK: begin
        if (!bus.door_closed || !bus.stopn) begin
          state_d = PAUSE;
        end else if (bus.tick) begin
          dig_dec = 1'b1;
          if (time_one) state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.stopn) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q;
          if (bus.tick) begin
            if (dcnt_q == DONE_LAST) begin
              state_d = IDLE;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are derived from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      mag_on_q   <= (state_d == COOK);
      done_q     <= (state_d == DONE);
      load_err_q <= load_err_d;
    end
  end

  bcd_down_digit #(.MAX_VAL(BCD_MAX_UNITS)) u_sec_ones (
    .clk(clock), .rst_n(clearn), .clr_i(dig_clr), .load_i(dig_load),
    .load_val_i(bus.data[3:0]), .en_i(dig_dec),
    .value_o(bus.sec_ones), .borrow_o(so_borrow), .zero_o(so_zero)
  );

  bcd_down_digit #(.MAX_VAL(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk(clock), .rst_n(clearn), .clr_i(dig_clr), .load_i(dig_load),
    .load_val_i(bus.data[7:4]), .en_i(so_borrow),
    .value_o(bus.sec_tens), .borrow_o(st_borrow), .zero_o(st_zero)
  );

  bcd_down_digit #(.MAX_VAL(BCD_MAX_UNITS)) u_min_ones (
    .clk(clock), .rst_n(clearn), .clr_i(dig_clr), .load_i(dig_load),
    .load_val_i(bus.data[11:8]), .en_i(st_borrow),
    .value_o(bus.min_ones), .borrow_o(mo_borrow), .zero_o(mo_zero)
  );

  bcd_down_digit #(.MAX_VAL(BCD_MAX_UNITS)) u_min_tens (
    .clk(clock), .rst_n(clearn), .clr_i(dig_clr), .load_i(dig_load),
    .load_val_i(bus.data[15:12]), .en_i(mo_borrow),
    .value_o(bus.min_tens), .borrow_o(mt_borrow_unused), .zero_o(mt_zero)
  );

  assign bus.state    = state_q;
  assign bus.mag_on   = mag_on_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed-vector bench for microwave_timer_ctrl with hand-computed
// expected time, state and flag values.
module tb_microwave_timer_ctrl;

  logic clock;
  logic clearn;
  int unsigned n_cmp;
  int unsigned n_err;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clock (clock),
    .clearn(clearn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [15:0] S_IDLE  = 16'd0;
  localparam logic [15:0] S_COOK  = 16'd1;
  localparam logic [15:0] S_PAUSE = 16'd2;
  localparam logic [15:0] S_DONE  = 16'd3;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tm();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.data  = v;
    bus.loadn = 1'b0;
    step();
    bus.loadn = 1'b1;
  endtask

  task automatic do_start();
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
  endtask

  task automatic do_stop();
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  logic [15:0] exp_12s [12] = '{
    16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
    16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000
  };

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.tick        = 1'b0;
    bus.data        = '0;
    bus.loadn       = 1'b1;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b1;
    clearn          = 1'b0;
    step();
    check_eq("rst_state", 16'(bus.state), S_IDLE);
    check_eq("rst_time", tm(), 16'h0000);
    check_eq("rst_mag", 16'(bus.mag_on), 16'd0);
    check_eq("rst_done", 16'(bus.done), 16'd0);
    check_eq("rst_lerr", 16'(bus.load_err), 16'd0);
    clearn = 1'b1;
    step();

    // 00:12 full cook to DONE and back to IDLE
    do_load(16'h0012);
    check_eq("ld12_time", tm(), 16'h0012);
    check_eq("ld12_lerr", 16'(bus.load_err), 16'd0);
    do_start();
    check_eq("st12_state", 16'(bus.state), S_COOK);
    check_eq("st12_mag", 16'(bus.mag_on), 16'd1);
    for (int i = 0; i < 12; i++) begin
      do_tick();
      check_eq("cnt12_time", tm(), exp_12s[i]);
      check_eq("cnt12_state", 16'(bus.state), (i == 11) ? S_DONE : S_COOK);
      check_eq("cnt12_mag", 16'(bus.mag_on), (i == 11) ? 16'd0 : 16'd1);
      step();
    end
    check_eq("done_hold", 16'(bus.done), 16'd1);
    do_tick();
    check_eq("done_t1", 16'(bus.state), S_DONE);
    do_tick();
    check_eq("done_t2", 16'(bus.done), 16'd1);
    do_tick();
    check_eq("done_t3_state", 16'(bus.state), S_IDLE);
    check_eq("done_t3_done", 16'(bus.done), 16'd0);

    // borrow across sec_tens and min_ones
    do_load(16'h0100);
    do_start();
    do_tick();
    check_eq("borrow_time", tm(), 16'h0059);
    check_eq("borrow_state", 16'(bus.state), S_COOK);
    do_load(16'h0999);
    check_eq("cook_ld_ign", tm(), 16'h0059);
    do_stop();
    do_stop();
    check_eq("clr_time", tm(), 16'h0000);

    // rejected loads
    do_load(16'h0070);
    check_eq("err70_pulse", 16'(bus.load_err), 16'd1);
    check_eq("err70_time", tm(), 16'h0000);
    step();
    check_eq("err70_one", 16'(bus.load_err), 16'd0);
    do_load(16'h9959);
    check_eq("ld_max", tm(), 16'h9959);
    do_load(16'h0A00);
    check_eq("errA_pulse", 16'(bus.load_err), 16'd1);
    check_eq("errA_time", tm(), 16'h9959);
    do_stop();

    // door opens coincident with tick
    do_load(16'h0031);
    do_start();
    do_tick();
    check_eq("door_pre", tm(), 16'h0030);
    bus.door_closed = 1'b0;
    do_tick();
    check_eq("door_state", 16'(bus.state), S_PAUSE);
    check_eq("door_time", tm(), 16'h0030);
    check_eq("door_mag", 16'(bus.mag_on), 16'd0);
    do_start();
    check_eq("door_st_ign", 16'(bus.state), S_PAUSE);
    bus.door_closed = 1'b1;
    do_start();
    check_eq("resume_state", 16'(bus.state), S_COOK);
    check_eq("resume_mag", 16'(bus.mag_on), 16'd1);
    do_tick();
    check_eq("resume_time", tm(), 16'h0029);
    do_stop();
    do_stop();

    // stop in COOK, stop in PAUSE, start at zero
    do_load(16'h0500);
    do_start();
    do_stop();
    check_eq("stop1_state", 16'(bus.state), S_PAUSE);
    check_eq("stop1_time", tm(), 16'h0500);
    do_stop();
    check_eq("stop2_state", 16'(bus.state), S_IDLE);
    check_eq("stop2_time", tm(), 16'h0000);
    do_start();
    check_eq("st_zero", 16'(bus.state), S_IDLE);

    // stop in DONE returns to IDLE at once
    do_load(16'h0001);
    do_start();
    do_tick();
    check_eq("d1_state", 16'(bus.state), S_DONE);
    do_stop();
    check_eq("dstop_state", 16'(bus.state), S_IDLE);
    check_eq("dstop_done", 16'(bus.done), 16'd0);

    // reset mid-COOK
    do_load(16'h0215);
    do_start();
    check_eq("pre_rst", 16'(bus.state), S_COOK);
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    check_eq("mrst_state", 16'(bus.state), S_IDLE);
    check_eq("mrst_time", tm(), 16'h0000);
    check_eq("mrst_mag", 16'(bus.mag_on), 16'd0);
    check_eq("mrst_done", 16'(bus.done), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 Parameter: DONE_TICKS, 3, number of tick pulses the done indication is held before returning to IDLE (range 1..15).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 clearn  input  1  reset, synchronous, active-low.
REQ-004 tick  input  1  one-cycle 1 Hz enable strobe.
REQ-005 data  input  16  BCD load value {min_tens, min_ones, sec_tens, sec_ones}.
REQ-006 loadn  input  1  active-low load request, sampled synchronously.
REQ-007 startn  input  1  active-low start request, sampled synchronously.
REQ-008 stopn  input  1  active-low stop/clear request, sampled synchronously.
REQ-009 door_closed  input  1  high = door closed.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD remaining time.
REQ-011 mag_on  output  1  registered magnetron enable; high only in COOK.
REQ-012 done  output  1  registered; high only in DONE.
REQ-013 load_err  output  1  registered one-cycle pulse on a rejected load.
REQ-014 state  output  3  registered current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE, COOK, PAUSE, DONE.
REQ-016 Per-cycle request priority SHALL be: door open > stopn > startn > loadn > tick.
REQ-017 loadn low in IDLE or PAUSE SHALL load data into the digits next edge if every digit is <=9 and sec_tens <=5; otherwise digits SHALL be unchanged and load_err SHALL pulse high for one cycle.
REQ-018 loadn SHALL be ignored in COOK and DONE.
REQ-019 startn low in IDLE or PAUSE with door_closed high and time != 00:00 SHALL enter COOK next edge; with time = 00:00, state SHALL be unchanged.
REQ-020 In COOK each tick SHALL decrement the time by one second: sec_ones 0->9 with borrow, sec_tens 0->5 with borrow, min_ones 0->9 with borrow, min_tens decremented on borrow.
REQ-021 A tick in COOK with time 00:01 SHALL set time 00:00 and enter DONE on the same edge.
REQ-022 door_closed low in COOK SHALL enter PAUSE next edge with no decrement that cycle, even if tick is high.
REQ-023 stopn low in COOK SHALL enter PAUSE with time held; stopn low in PAUSE or IDLE SHALL clear time to 00:00 and enter/stay IDLE.
REQ-024 In DONE, done SHALL stay high for DONE_TICKS tick pulses, then go to IDLE; stopn low in DONE SHALL go to IDLE immediately.
REQ-025 startn while door_closed is low SHALL be ignored in every state.
REQ-026 mag_on SHALL equal (state == COOK) registered, so it drops on the same edge that leaves COOK.
REQ-027 Digits SHALL never hold a non-BCD value or sec_tens > 5.

Reset
REQ-028 clearn low at a clock edge SHALL force state IDLE, time 00:00, mag_on 0, done 0, load_err 0, done-tick counter 0, overriding all other inputs including mid-COOK.
REQ-029 Outputs SHALL be defined from the first edge with clearn low; no initial-value reliance.

Structure
REQ-030 Package microwave_pkg SHALL hold the state encoding (IDLE=0, COOK=1, PAUSE=2, DONE=3), BCD_MAX_UNITS=9, BCD_MAX_SEC_TENS=5.
REQ-031 One sub-module bcd_down_digit (parameterised max value, load, enable, borrow-out, zero flag) SHALL be instantiated four times; the FSM and done-tick counter SHALL live in the top.

Verification
REQ-032 Load 0x0012, start, door closed, 12 ticks -> time counts 00:11..00:00, DONE on 12th tick, mag_on 0 same edge, done high for 3 ticks, then IDLE.
REQ-033 Load 0x0100, start, 1 tick -> 00:59 (borrow across sec_tens and min_ones).
REQ-034 Load 0x0070 -> load_err one-cycle pulse, time unchanged at 00:00.
REQ-035 COOK at 00:30, door opens coincident with tick -> PAUSE, time stays 00:30, mag_on 0 next edge; close door, start -> COOK resumes.
REQ-036 COOK at 05:00, stopn -> PAUSE at 05:00; stopn again -> IDLE at 00:00; startn at 00:00 -> stays IDLE.
REQ-037 clearn low for one edge mid-COOK at 02:15 -> IDLE, 00:00, mag_on 0, done 0 next edge.
